// File: rtl/itof_arbiter.sv
// Two-requester round-robin front end for a shared combinational int32->float32
// converter, holding the operand for LATENCY cycles before capturing the result.
module itof_arbiter #(
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_src,
  output logic        resp0_valid,
  input  logic        resp0_ready,
  output logic [31:0] resp0_data,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_src,
  output logic        resp1_valid,
  input  logic        resp1_ready,
  output logic [31:0] resp1_data,
  output logic        busy
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t        state;
  logic          owner;
  logic          last;
  logic [CW-1:0] cnt;
  logic [31:0]   operand;
  logic [31:0]   conv;
  logic          grant0;
  logic          grant1;

  // Round-to-nearest-even conversion; the magnitude is normalised so its
  // leading one sits at bit 31, leaving mantissa, guard and sticky at fixed bits.
  function automatic logic [31:0] itof(input logic [31:0] x);
    logic        sign;
    logic [31:0] mag;
    logic [31:0] norm;
    logic [4:0]  p;
    logic [30:0] base;
    logic        round_up;
    logic [31:0] res;
    sign = x[31];
    mag  = sign ? (~x + 32'd1) : x;
    p    = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (mag[i]) p = i[4:0];
    end
    norm     = mag << (5'd31 - p);
    base     = {8'(p) + 8'd127, norm[30:8]};
    round_up = norm[7] & ((|norm[6:0]) | norm[8]);
    if (mag == '0) res = '0;
    else           res = {sign, base + 31'(round_up)};
    return res;
  endfunction

  assign conv = itof(operand);

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE && !rst) begin
      grant0 = req0_valid && (!req1_valid || last);
      grant1 = req1_valid && (!req0_valid || !last);
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last        <= 1'b1;
      cnt         <= '0;
      operand     <= '0;
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      resp0_data  <= '0;
      resp1_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            operand <= grant0 ? req0_src : req1_src;
            owner   <= grant1;
            last    <= grant1;
            cnt     <= CW'(LATENCY - 1);
            state   <= EXEC;
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            if (owner) begin
              resp1_data  <= conv;
              resp1_valid <= 1'b1;
            end else begin
              resp0_data  <= conv;
              resp0_valid <= 1'b1;
            end
            state <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (owner ? resp1_ready : resp0_ready) begin
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_itof_arbiter.sv
// Directed bench for itof_arbiter: instance 0 uses LATENCY=2, instances 1 and 2
// use LATENCY=1 and LATENCY=5 for latency checks.
module tb_itof_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        r0v [3];
  logic        r0r [3];
  logic [31:0] r0s [3];
  logic        p0v [3];
  logic        p0r [3];
  logic [31:0] p0d [3];
  logic        r1v [3];
  logic        r1r [3];
  logic [31:0] r1s [3];
  logic        p1v [3];
  logic        p1r [3];
  logic [31:0] p1d [3];
  logic        bsy [3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    itof_arbiter #(.LATENCY(g == 0 ? 2 : (g == 1 ? 1 : 5))) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (r0v[g]),
      .req0_ready (r0r[g]),
      .req0_src   (r0s[g]),
      .resp0_valid(p0v[g]),
      .resp0_ready(p0r[g]),
      .resp0_data (p0d[g]),
      .req1_valid (r1v[g]),
      .req1_ready (r1r[g]),
      .req1_src   (r1s[g]),
      .resp1_valid(p1v[g]),
      .resp1_ready(p1r[g]),
      .resp1_data (p1d[g]),
      .busy       (bsy[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Called at the first negedge after the accept edge; returns cycles to resp_valid.
  task automatic wait_resp(input int d, input int p, output int n);
    n = 0;
    while (((p == 0) ? p0v[d] : p1v[d]) !== 1'b1 && n < 30) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 30) check("resp_timeout", 32'(n), 32'(0));
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1;
  endtask

  task automatic serve(input int d, input int p, input logic [31:0] src,
                       input logic [31:0] exp, input int lat);
    int n;
    if (p == 0) begin r0v[d] = 1'b1; r0s[d] = src; end
    else        begin r1v[d] = 1'b1; r1s[d] = src; end
    #1;
    check("accept_ready", (p == 0) ? r0r[d] : r1r[d], 1'b1);
    check("other_ready",  (p == 0) ? r1r[d] : r0r[d], 1'b0);
    @(negedge clk); #1;
    if (p == 0) begin r0v[d] = 1'b0; r0s[d] = ~src; end
    else        begin r1v[d] = 1'b0; r1s[d] = ~src; end
    wait_resp(d, p, n);
    check("latency", 32'(n), 32'(lat));
    check("resp_data", (p == 0) ? p0d[d] : p1d[d], exp);
    check("other_valid", (p == 0) ? p1v[d] : p0v[d], 1'b0);
    @(negedge clk); #1;
    check("idle_after", bsy[d], 1'b0);
  endtask

  initial begin
    int n;
    logic who;
    for (int i = 0; i < 3; i++) begin
      r0v[i] = 1'b0; r0s[i] = '0; p0r[i] = 1'b1;
      r1v[i] = 1'b0; r1s[i] = '0; p1r[i] = 1'b1;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_busy", bsy[0], 1'b0);
    check("rst_v0",   p0v[0], 1'b0);
    check("rst_v1",   p1v[0], 1'b0);
    check("rst_d0",   p0d[0], 32'h0);
    check("rst_d1",   p1d[0], 32'h0);

    serve(0, 0, 32'd1,         32'h3F80_0000, 2);
    serve(0, 0, 32'd0,         32'h0000_0000, 2);
    serve(0, 1, 32'h8000_0000, 32'hCF00_0000, 2);
    serve(0, 0, 32'h7FFF_FFFF, 32'h4F00_0000, 2);

    // fairness with both requesters continuously valid
    do_reset();
    r0v[0] = 1'b1; r0s[0] = 32'hFFFF_FFFF;
    r1v[0] = 1'b1; r1s[0] = 32'd100;
    #1;
    for (int g = 0; g < 4; g++) begin
      n = 0;
      while (!(r0r[0] | r1r[0]) && n < 30) begin
        @(negedge clk); #1;
        n++;
      end
      check("fair_grant_seen", r0r[0] | r1r[0], 1'b1);
      check("fair_one_ready", r0r[0] & r1r[0], 1'b0);
      who = r1r[0];
      check("fair_order", who, 32'(g % 2));
      @(negedge clk); #1;
      wait_resp(0, who ? 1 : 0, n);
      check("fair_data", who ? p1d[0] : p0d[0], who ? 32'h42C8_0000 : 32'hBF80_0000);
      check("fair_other_valid", who ? p0v[0] : p1v[0], 1'b0);
      @(negedge clk); #1;
    end
    r0v[0] = 1'b0;
    r1v[0] = 1'b0;

    // response backpressure on port 1 while port 0 waits
    @(negedge clk); #1;
    r1v[0] = 1'b1; r1s[0] = 32'd16777217; p1r[0] = 1'b0;
    #1;
    check("bp_ready1", r1r[0], 1'b1);
    @(negedge clk); #1;
    r1v[0] = 1'b0; r0v[0] = 1'b1; r0s[0] = 32'd5;
    n = 0;
    while (!p1v[0] && n < 30) begin
      check("bp_hold_r0", r0r[0], 1'b0);
      @(negedge clk); #1;
      n++;
    end
    check("bp_latency", 32'(n), 32'd2);
    repeat (5) begin
      check("bp_valid", p1v[0], 1'b1);
      check("bp_data", p1d[0], 32'h4B80_0000);
      check("bp_r0_ready", r0r[0], 1'b0);
      @(negedge clk); #1;
    end
    p1r[0] = 1'b1;
    @(negedge clk); #1;
    check("bp_release", p1v[0], 1'b0);
    check("bp_r0_granted", r0r[0], 1'b1);
    @(negedge clk); #1;
    r0v[0] = 1'b0;
    wait_resp(0, 0, n);
    check("bp_r0_data", p0d[0], 32'h40A0_0000);
    check("bp_keep_d1", p1d[0], 32'h4B80_0000);
    @(negedge clk); #1;

    // reset in the cycle after accept aborts the conversion
    r0v[0] = 1'b1; r0s[0] = 32'd7;
    #1;
    check("abort_ready", r0r[0], 1'b1);
    @(negedge clk); #1;
    r0v[0] = 1'b0;
    check("abort_busy_exec", bsy[0], 1'b1);
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    check("abort_busy", bsy[0], 1'b0);
    check("abort_v0", p0v[0], 1'b0);
    check("abort_v1", p1v[0], 1'b0);
    check("abort_d0", p0d[0], 32'h0);
    repeat (4) @(negedge clk);
    #1;
    check("abort_no_resp", p0v[0], 1'b0);
    serve(0, 1, 32'd3, 32'h4040_0000, 2);

    // other latency builds
    serve(1, 0, 32'd1,   32'h3F80_0000, 1);
    serve(2, 1, 32'd100, 32'h42C8_0000, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
